calendar_counter: RTL and testbench

//   Parametrised BCD time-of-day and calendar counter (YY-MM-DD hh:mm:ss), 2000-2099.

---
 rtl/calendar_counter.sv | 161 ++++++++++++++++
 tb/tb_calendar_counter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calendar_counter.sv
// BCD time-of-day and calendar counter (YY-MM-DD hh:mm:ss, 2000-2099) with tick prescaler,
// validated loads and 12/24-hour display. Optional weekday tracking: define DAY_OF_WEEK_EN.
module calendar_counter #(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned PS_W     = $clog2(TICK_DIV + 1)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inc_i,
  input  logic        h12_i,
  input  logic        load_i,
  input  logic [23:0] load_date_i,
  input  logic [23:0] load_time_i,
`ifdef DAY_OF_WEEK_EN
  input  logic [2:0]  load_wday_i,
  output logic [2:0]  wday_o,
`endif
  output logic [23:0] date_bcd_o,
  output logic [23:0] time_bcd_o,
  output logic        pm_o,
  output logic        sec_tick_o,
  output logic        min_tick_o,
  output logic        load_err_o,
  output logic        time_valid_o
);

  logic [6:0]      year;
  logic [3:0]      month;
  logic [4:0]      day;
  logic [4:0]      hour;
  logic [5:0]      minute;
  logic [5:0]      second;
  logic [PS_W-1:0] ps;

  logic [6:0] ld_year, ld_month, ld_day, ld_hour, ld_min, ld_sec;
  logic       nib_ok, load_ok;
  logic [4:0] disp_hour;

  function automatic logic [6:0] bcd2bin(input logic [7:0] b);
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  function automatic logic [4:0] days_in(input logic [3:0] m, input logic [6:0] y);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      4'd2:                    return (y[1:0] == 2'd0) ? 5'd29 : 5'd28;
      default:                 return 5'd31;
    endcase
  endfunction

  // Range checks use the full decoded width so out-of-range BCD cannot alias into range.
  always_comb begin
    ld_year  = bcd2bin(load_date_i[23:16]);
    ld_month = bcd2bin(load_date_i[15:8]);
    ld_day   = bcd2bin(load_date_i[7:0]);
    ld_hour  = bcd2bin(load_time_i[23:16]);
    ld_min   = bcd2bin(load_time_i[15:8]);
    ld_sec   = bcd2bin(load_time_i[7:0]);
    nib_ok   = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      if (load_date_i[4*i +: 4] > 4'd9 || load_time_i[4*i +: 4] > 4'd9) nib_ok = 1'b0;
    end
    load_ok = nib_ok
           && ld_month >= 7'd1 && ld_month <= 7'd12
           && ld_day >= 7'd1
           && ld_day <= {2'b00, days_in(ld_month[3:0], ld_year)}
           && ld_hour <= 7'd23 && ld_min <= 7'd59 && ld_sec <= 7'd59;
`ifdef DAY_OF_WEEK_EN
    if (load_wday_i == 3'd7) load_ok = 1'b0;
`endif
  end

  always_ff @(posedge clk_i) begin
    sec_tick_o <= 1'b0;
    min_tick_o <= 1'b0;
    load_err_o <= 1'b0;
    if (!rst_ni) begin
      year         <= '0;
      month        <= 4'd1;
      day          <= 5'd1;
      hour         <= '0;
      minute       <= '0;
      second       <= '0;
      ps           <= '0;
      time_valid_o <= 1'b0;
`ifdef DAY_OF_WEEK_EN
      wday_o       <= 3'd5;
`endif
    end else if (load_i) begin
      // A load always consumes the cycle; a coincident inc_i is dropped either way.
      if (load_ok) begin
        year         <= ld_year;
        month        <= ld_month[3:0];
        day          <= ld_day[4:0];
        hour         <= ld_hour[4:0];
        minute       <= ld_min[5:0];
        second       <= ld_sec[5:0];
        ps           <= '0;
        time_valid_o <= 1'b1;
`ifdef DAY_OF_WEEK_EN
        wday_o       <= load_wday_i;
`endif
      end else begin
        load_err_o <= 1'b1;
      end
    end else if (inc_i) begin
      if (ps == PS_W'(TICK_DIV - 1)) begin
        ps         <= '0;
        sec_tick_o <= 1'b1;
        if (second == 6'd59) begin
          second     <= '0;
          min_tick_o <= 1'b1;
          if (minute == 6'd59) begin
            minute <= '0;
            if (hour == 5'd23) begin
              hour <= '0;
`ifdef DAY_OF_WEEK_EN
              wday_o <= (wday_o == 3'd6) ? 3'd0 : wday_o + 3'd1;
`endif
              if (day == days_in(month, year)) begin
                day <= 5'd1;
                if (month == 4'd12) begin
                  month <= 4'd1;
                  year  <= (year == 7'd99) ? 7'd0 : year + 7'd1;
                end else begin
                  month <= month + 4'd1;
                end
              end else begin
                day <= day + 5'd1;
              end
            end else begin
              hour <= hour + 5'd1;
            end
          end else begin
            minute <= minute + 6'd1;
          end
        end else begin
          second <= second + 6'd1;
        end
      end else begin
        ps <= ps + PS_W'(1);
      end
    end
  end

  always_comb begin
    disp_hour = hour;
    if (h12_i) begin
      if (hour == 5'd0)       disp_hour = 5'd12;
      else if (hour > 5'd12)  disp_hour = hour - 5'd12;
    end
    pm_o       = (hour >= 5'd12);
    date_bcd_o = {bin2bcd(year), bin2bcd(7'(month)), bin2bcd(7'(day))};
    time_bcd_o = {bin2bcd(7'(disp_hour)), bin2bcd(7'(minute)), bin2bcd(7'(second))};
  end

endmodule

// File: tb/tb_calendar_counter.sv
// Self-checking bench for calendar_counter: vector table, directed corner sequences,
// and randomized traffic against a day-index / second-of-day reference model.
module tb_calendar_counter;
  localparam int TD = 1;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, inc, h12, load;
  logic [23:0] ld_date, ld_time;
  logic [23:0] date, tim;
  logic        pm, st, mt, err, valid;
  logic        inc4, load4, h12_4;
  logic [23:0] ld_date4, ld_time4;
  logic [23:0] date4, tim4;
  logic        pm4, st4, mt4, err4, valid4;
`ifdef DAY_OF_WEEK_EN
  logic [2:0]  ld_wday, wday, ld_wday4, wday4;
`endif

  calendar_counter #(.TICK_DIV(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .inc_i(inc), .h12_i(h12), .load_i(load),
    .load_date_i(ld_date), .load_time_i(ld_time),
`ifdef DAY_OF_WEEK_EN
    .load_wday_i(ld_wday), .wday_o(wday),
`endif
    .date_bcd_o(date), .time_bcd_o(tim), .pm_o(pm), .sec_tick_o(st),
    .min_tick_o(mt), .load_err_o(err), .time_valid_o(valid)
  );

  calendar_counter #(.TICK_DIV(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .inc_i(inc4), .h12_i(h12_4), .load_i(load4),
    .load_date_i(ld_date4), .load_time_i(ld_time4),
`ifdef DAY_OF_WEEK_EN
    .load_wday_i(ld_wday4), .wday_o(wday4),
`endif
    .date_bcd_o(date4), .time_bcd_o(tim4), .pm_o(pm4), .sec_tick_o(st4),
    .min_tick_o(mt4), .load_err_o(err4), .time_valid_o(valid4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: days since 2000-01-01 plus seconds since midnight.
  int m_sod, m_day, m_ps, m_wday;
  bit m_valid, e_sec, e_min, e_err;

  function automatic int dim(int m, int y);
    case (m)
      4, 6, 9, 11: return 30;
      2:           return (y % 4 == 0) ? 29 : 28;
      default:     return 31;
    endcase
  endfunction

  function automatic int ylen(int y);
    return (y % 4 == 0) ? 366 : 365;
  endfunction

  function automatic logic [7:0] bcd8(int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic int unbcd(logic [7:0] b);
    if (b[7:4] > 9 || b[3:0] > 9) return -1;
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic int ymd2idx(int y, int m, int d);
    int idx = 0;
    for (int yy = 0; yy < y; yy++) idx += ylen(yy);
    for (int mm = 1; mm < m; mm++) idx += dim(mm, y);
    return idx + d - 1;
  endfunction

  function automatic logic [23:0] idx2bcd(int idx);
    int y = 0, m = 1;
    while (idx >= ylen(y)) begin idx -= ylen(y); y++; end
    while (idx >= dim(m, y)) begin idx -= dim(m, y); m++; end
    return {bcd8(y), bcd8(m), bcd8(idx + 1)};
  endfunction

  function automatic bit ld_valid(logic [23:0] dt, logic [23:0] tm);
    int y, m, d, h, mi, s;
    y = unbcd(dt[23:16]); m = unbcd(dt[15:8]); d = unbcd(dt[7:0]);
    h = unbcd(tm[23:16]); mi = unbcd(tm[15:8]); s = unbcd(tm[7:0]);
    if (y < 0 || m < 0 || d < 0 || h < 0 || mi < 0 || s < 0) return 0;
    if (m < 1 || m > 12 || d < 1 || d > dim(m, y)) return 0;
    if (h > 23 || mi > 59 || s > 59) return 0;
`ifdef DAY_OF_WEEK_EN
    if (ld_wday == 3'd7) return 0;
`endif
    return 1;
  endfunction

  task automatic model_apply();
    e_sec = 0; e_min = 0; e_err = 0;
    if (!rst_n) begin
      m_sod = 0; m_day = 0; m_ps = 0; m_valid = 0; m_wday = 5;
    end else if (load) begin
      if (ld_valid(ld_date, ld_time)) begin
        m_day = ymd2idx(unbcd(ld_date[23:16]), unbcd(ld_date[15:8]), unbcd(ld_date[7:0]));
        m_sod = unbcd(ld_time[23:16]) * 3600 + unbcd(ld_time[15:8]) * 60 + unbcd(ld_time[7:0]);
        m_ps = 0; m_valid = 1;
`ifdef DAY_OF_WEEK_EN
        m_wday = int'(ld_wday);
`endif
      end else e_err = 1;
    end else if (inc) begin
      m_ps++;
      if (m_ps == TD) begin
        m_ps = 0; e_sec = 1; m_sod++;
        if (m_sod % 60 == 0) e_min = 1;
        if (m_sod == 86400) begin
          m_sod = 0; m_day = (m_day + 1) % 36525; m_wday = (m_wday + 1) % 7;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    int h, dh;
    h  = m_sod / 3600;
    dh = h12 ? ((h + 11) % 12) + 1 : h;
    chk({tag, " date"}, date, idx2bcd(m_day));
    chk({tag, " time"}, tim, {bcd8(dh), bcd8((m_sod / 60) % 60), bcd8(m_sod % 60)});
    chk({tag, " pm"}, pm, h >= 12);
    chk({tag, " sec_tick"}, st, e_sec);
    chk({tag, " min_tick"}, mt, e_min);
    chk({tag, " load_err"}, err, e_err);
    chk({tag, " valid"}, valid, m_valid);
`ifdef DAY_OF_WEEK_EN
    chk({tag, " wday"}, wday, m_wday);
`endif
  endtask

  task automatic step();
    model_apply();
    @(posedge clk);
    #1;
  endtask

  task automatic step4(input logic i, input logic l, input logic [23:0] dt, input logic [23:0] tm);
    inc4 = i; load4 = l; ld_date4 = dt; ld_time4 = tm;
    step();
    inc4 = 1'b0; load4 = 1'b0;
  endtask

  task automatic load_inc(input logic [23:0] dt, input logic [23:0] tm);
    ld_date = dt; ld_time = tm; load = 1'b1; step(); load = 1'b0;
    inc = 1'b1; step(); inc = 1'b0;
  endtask

  typedef struct {
    logic [23:0] dt;
    logic [23:0] tm;
    logic        h12;
    logic        e_err;
    logic [23:0] e_date;
    logic [23:0] e_time;
    logic        e_pm;
    logic        e_valid;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{24'h001301, 24'h000000, 1'b0, 1'b1, 24'h000101, 24'h000000, 1'b0, 1'b0};
    vecs[1]  = '{24'h000431, 24'h000000, 1'b0, 1'b1, 24'h000101, 24'h000000, 1'b0, 1'b0};
    vecs[2]  = '{24'h000101, 24'h00000A, 1'b0, 1'b1, 24'h000101, 24'h000000, 1'b0, 1'b0};
    vecs[3]  = '{24'h000230, 24'h000000, 1'b0, 1'b1, 24'h000101, 24'h000000, 1'b0, 1'b0};
    vecs[4]  = '{24'h000101, 24'h240000, 1'b0, 1'b1, 24'h000101, 24'h000000, 1'b0, 1'b0};
    vecs[5]  = '{24'h010229, 24'h000000, 1'b0, 1'b1, 24'h000101, 24'h000000, 1'b0, 1'b0};
    vecs[6]  = '{24'h0A0101, 24'h000000, 1'b0, 1'b1, 24'h000101, 24'h000000, 1'b0, 1'b0};
    vecs[7]  = '{24'h240229, 24'h000000, 1'b1, 1'b0, 24'h240229, 24'h120000, 1'b0, 1'b1};
    vecs[8]  = '{24'h240229, 24'h120000, 1'b1, 1'b0, 24'h240229, 24'h120000, 1'b1, 1'b1};
    vecs[9]  = '{24'h240229, 24'h130000, 1'b1, 1'b0, 24'h240229, 24'h010000, 1'b1, 1'b1};
    vecs[10] = '{24'h240229, 24'h235959, 1'b0, 1'b0, 24'h240229, 24'h235959, 1'b1, 1'b1};
    vecs[11] = '{24'h240229, 24'h235959, 1'b1, 1'b0, 24'h240229, 24'h115959, 1'b1, 1'b1};
    vecs[12] = '{24'h991231, 24'h010203, 1'b1, 1'b0, 24'h991231, 24'h010203, 1'b0, 1'b1};
    vecs[13] = '{24'h990001, 24'h000000, 1'b1, 1'b1, 24'h991231, 24'h010203, 1'b0, 1'b1};
    vecs[14] = '{24'h990160, 24'h000000, 1'b1, 1'b1, 24'h991231, 24'h010203, 1'b0, 1'b1};

    rst_n = 1'b0; inc = 1'b0; h12 = 1'b0; load = 1'b0; ld_date = '0; ld_time = '0;
    inc4 = 1'b0; load4 = 1'b0; h12_4 = 1'b0; ld_date4 = '0; ld_time4 = '0;
`ifdef DAY_OF_WEEK_EN
    ld_wday = '0; ld_wday4 = '0;
`endif

    // Reset
    step();
    chk("reset date", date, 24'h000101);
    chk("reset time", tim, 24'h000000);
    chk("reset valid", valid, 1'b0);
    chk("reset pm", pm, 1'b0);
    chk("reset err", err, 1'b0);
    chk("reset4 time", tim4, 24'h000000);
    check_all("reset model");
    rst_n = 1'b1;

    // Prescaler, TICK_DIV=4
    step4(1'b0, 1'b1, 24'h000101, 24'h000010);
    chk("ps load time", tim4, 24'h000010);
    chk("ps load valid", valid4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step4(1'b1, 1'b0, '0, '0);
      chk($sformatf("ps inc%0d time", i), tim4, 24'h000010);
      chk($sformatf("ps inc%0d tick", i), st4, 1'b0);
    end
    step4(1'b1, 1'b0, '0, '0);
    chk("ps 4th time", tim4, 24'h000011);
    chk("ps 4th tick", st4, 1'b1);
    step4(1'b0, 1'b0, '0, '0);
    chk("ps idle tick", st4, 1'b0);
    step4(1'b1, 1'b0, '0, '0);
    step4(1'b1, 1'b0, '0, '0);
    step4(1'b1, 1'b1, 24'h000101, 24'h000020);
    chk("ps load+inc time", tim4, 24'h000020);
    chk("ps load+inc tick", st4, 1'b0);
    chk("ps load+inc err", err4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step4(1'b1, 1'b0, '0, '0);
      chk($sformatf("ps clr inc%0d time", i), tim4, 24'h000020);
    end
    step4(1'b1, 1'b0, '0, '0);
    chk("ps clr 4th time", tim4, 24'h000021);
    chk("ps clr 4th tick", st4, 1'b1);
    check_all("after ps");

    // Load validation and display table
    for (int i = 0; i < 15; i++) begin
      ld_date = vecs[i].dt; ld_time = vecs[i].tm; h12 = vecs[i].h12; load = 1'b1;
      step();
      load = 1'b0;
      chk($sformatf("vec%0d err", i), err, vecs[i].e_err);
      chk($sformatf("vec%0d date", i), date, vecs[i].e_date);
      chk($sformatf("vec%0d time", i), tim, vecs[i].e_time);
      chk($sformatf("vec%0d pm", i), pm, vecs[i].e_pm);
      chk($sformatf("vec%0d valid", i), valid, vecs[i].e_valid);
      chk($sformatf("vec%0d tick", i), st, 1'b0);
      check_all($sformatf("vec%0d model", i));
      step();
      chk($sformatf("vec%0d err clear", i), err, 1'b0);
    end

    // Leap year, non-leap year, century wrap
    h12 = 1'b0;
    load_inc(24'h240228, 24'h235959);
    chk("leap date", date, 24'h240229);
    chk("leap time", tim, 24'h000000);
    chk("leap sec_tick", st, 1'b1);
    chk("leap min_tick", mt, 1'b1);
    check_all("leap model");
    load_inc(24'h230228, 24'h235959);
    chk("nonleap date", date, 24'h230301);
    check_all("nonleap model");
`ifdef DAY_OF_WEEK_EN
    ld_wday = 3'd4;
`endif
    load_inc(24'h991231, 24'h235959);
    chk("century date", date, 24'h000101);
    chk("century time", tim, 24'h000000);
`ifdef DAY_OF_WEEK_EN
    chk("century wday", wday, 3'd5);
`endif
    check_all("century model");

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int r, y, m, d, hh, mi, s;
      h12 = 1'($urandom % 2);
      r = int'($urandom % 100);
      load = 1'b0; inc = 1'b0;
      if (r < 4) begin
        y = int'($urandom % 100);
        m = ($urandom % 8 == 0) ? int'($urandom % 16) : 1 + int'($urandom % 12);
        case ($urandom % 4)
          0: d = 28 + int'($urandom % 4);
          1: d = int'($urandom % 40);
          default: d = 1 + int'($urandom % 31);
        endcase
        if ($urandom % 2 == 0) begin
          hh = 23; mi = 59; s = 50 + int'($urandom % 10);
        end else begin
          hh = int'($urandom % 26); mi = int'($urandom % 61); s = int'($urandom % 61);
        end
        ld_date = {bcd8(y), bcd8(m), bcd8(d)};
        ld_time = {bcd8(hh), bcd8(mi), bcd8(s)};
        if ($urandom % 16 == 0) ld_time[3:0] = 4'hB;
`ifdef DAY_OF_WEEK_EN
        ld_wday = 3'($urandom % 8);
`endif
        load = 1'b1;
        inc = 1'($urandom % 2);
      end else begin
        inc = (r < 75);
      end
      step();
      check_all($sformatf("rand%0d", c));
    end
    load = 1'b0; inc = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
